if_prefetch: RTL and testbench

Instruction-fetch prefetch buffer for the Mips31 CPU. It owns the single combinational read port of the 2K-word instruction memory (`_imem`). It runs the fetch PC ahead of the decode stage and streams fetched words into a small FIFO. The decode stage drains the FIFO through a valid/ready handshake, and a branch/jump redirect flushes the FIFO and restarts fetch.

---
 rtl/if_prefetch.sv | 100 ++++++++++
 tb/tb_if_prefetch.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch buffer: runs fetch_pc ahead of decode into a DEPTH-entry FIFO.
// Latency: word enqueued on edge N is visible on instr after N; redirect adds one bubble cycle.
// Backpressure: stops enqueueing when full or fetch_en=0; drain via instr_valid/instr_ready.
module if_prefetch #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] TEXT_BASE = 32'h0040_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_en,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [10:0]              imem_addr,
  input  logic [31:0]              imem_rd,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   word_mem_q [DEPTH];

  logic [31:0]   pc_offset;
  logic          push;
  logic          pop;

  // Byte offset from TEXT_BASE; word index taken modulo 2048 so out-of-range PCs alias.
  assign pc_offset = fetch_pc_q - TEXT_BASE;
  assign imem_addr = 11'((pc_offset >> 2) & 32'h0000_07FF);

  // No full-bypass: a full FIFO never accepts a push, even alongside a pop.
  assign push = fetch_en && !redirect && (count_q < CW'(DEPTH));
  assign pop  = instr_valid && instr_ready;

  assign instr_valid = (count_q != '0);
  assign instr       = word_mem_q[rd_ptr_q];
  assign instr_pc    = pc_mem_q[rd_ptr_q];
  assign fifo_count  = count_q;

  // Next-state for PC, pointers and occupancy; redirect overrides push and pop.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      // Masking keeps the target word-aligned regardless of the low two bits.
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset clears every FIFO entry so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= TEXT_BASE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        word_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
        word_mem_q[wr_ptr_q] <= imem_rd;
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: directed scenarios then randomized traffic.
// Reference model is a queue of {pc, word} plus a fetch PC, updated once per edge.
// Outputs are sampled 1 time unit after each rising edge.
module tb_if_prefetch;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] TB_BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [10:0] imem_addr;
  logic [31:0] imem_rd;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  logic [31:0] mem [2048];
  assign imem_rd = mem[imem_addr];

  if_prefetch #(.DEPTH(DEPTH), .TEXT_BASE(TB_BASE)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fifo_count(fifo_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  ent_t        mq [$];
  logic [31:0] m_pc;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [10:0] addr_of(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - TB_BASE;
    return off[12:2];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc = TB_BASE;
  endtask

  task automatic check_model();
    check("count", {29'd0, fifo_count}, mq.size());
    check("valid", {31'd0, instr_valid}, {31'd0, mq.size() != 0});
    check("imem_addr", {21'd0, imem_addr}, {21'd0, addr_of(m_pc)});
    if (mq.size() != 0) begin
      check("instr", instr, mq[0].word);
      check("instr_pc", instr_pc, mq[0].pc);
    end
  endtask

  // One clock edge: predict from pre-edge inputs and model state, then compare.
  task automatic cycle();
    bit   do_push;
    bit   do_pop;
    ent_t e;
    do_push = fetch_en && !redirect && (mq.size() < DEPTH);
    do_pop  = (mq.size() != 0) && instr_ready;
    e.pc    = m_pc;
    e.word  = mem[addr_of(m_pc)];
    @(posedge clk);
    if (redirect) begin
      mq.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
    check_model();
  endtask

  logic [10:0] held_addr;

  initial begin
    for (int k = 0; k < 2048; k++) mem[k] = 32'h1000_0000 + k;
    rst_n       = 1'b0;
    fetch_en    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    model_reset();

    // Reset state
    #2;
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    check("rst_addr", {21'd0, imem_addr}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill with consumer stalled
    fetch_en = 1'b1;
    repeat (4) cycle();
    check("fill_count", {29'd0, fifo_count}, 32'd4);
    check("fill_instr", instr, 32'h1000_0000);
    check("fill_pc", instr_pc, 32'h0040_0000);
    repeat (2) cycle();
    check("fill_addr", {21'd0, imem_addr}, 32'd4);

    // Redirect with full FIFO, unaligned target
    redirect    = 1'b1;
    redirect_pc = 32'h0040_0103;
    cycle();
    redirect = 1'b0;
    check("redir_count", {29'd0, fifo_count}, 32'd0);
    check("redir_valid", {31'd0, instr_valid}, 32'd0);
    check("redir_addr", {21'd0, imem_addr}, 32'h040);
    cycle();
    check("redir_pc", instr_pc, 32'h0040_0100);

    // Streaming from reset
    rst_n = 1'b0;
    #1;
    model_reset();
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("stream_count", {29'd0, fifo_count}, 32'd1);
      check("stream_pc", instr_pc, TB_BASE + 32'(i) * 4);
    end

    // Redirect coinciding with a pop
    redirect    = 1'b1;
    redirect_pc = 32'h0040_0200;
    cycle();
    redirect = 1'b0;
    cycle();
    check("coinc_pc", instr_pc, 32'h0040_0200);
    check("coinc_instr", instr, 32'h1000_0080);

    // Wrap-around at the top of IMEM
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0040_1FFC;
    cycle();
    redirect = 1'b0;
    check("wrap_addr0", {21'd0, imem_addr}, 32'd2047);
    cycle();
    check("wrap_addr1", {21'd0, imem_addr}, 32'd0);
    check("wrap_pc0", instr_pc, 32'h0040_1FFC);
    cycle();
    instr_ready = 1'b1;
    cycle();
    check("wrap_pc1", instr_pc, 32'h0040_2000);
    check("wrap_instr1", instr, 32'h1000_0000);

    // Halt: drain while imem_addr holds
    fetch_en  = 1'b0;
    held_addr = imem_addr;
    repeat (3) begin
      cycle();
      check("halt_addr", {21'd0, imem_addr}, {21'd0, held_addr});
    end
    check("halt_count", {29'd0, fifo_count}, 32'd0);
    fetch_en = 1'b1;
    cycle();
    check("resume_pc", instr_pc, 32'h0040_2000 + 32'd8);

    // Asynchronous reset pulse between edges
    instr_ready = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_valid", {31'd0, instr_valid}, 32'd0);
    check("arst_instr", instr, 32'd0);
    check_model();
    #1 rst_n = 1'b1;
    repeat (3) cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      fetch_en    = ($urandom_range(0, 3) != 0);
      instr_ready = $urandom_range(0, 1) != 0;
      redirect    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) != 0) redirect_pc = TB_BASE + $urandom_range(0, 16'hFFFF);
      else                           redirect_pc = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
